operand2_seq: RTL and testbench
===============================

# operand2_seq

Multi-cycle sequenced operand-2 generator for the execute stage. It computes the ARM data-processing second operand and the shifter carry-out from a start/done handshake. The rotate/shift distance is consumed STEP bits per cycle by an FSM instead of an unrolled combinational loop. It also covers register-specified shifts (`shift_operand[4]=1`, amount from Rs) and the ARM #0 special encodings. The hazard unit stalls the pipeline while `busy` is high.

## Interface
- STEP, default 4: bits shifted/rotated per SHIFT cycle; power of two, 1..32.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted in IDLE or DONE only, ignored in SHIFT.
- imm  in  1  immediate (rotated imm8) form.
- mem_en  in  1  memory offset form; has priority over imm.
- shift_operand  in  12  instruction bits [11:0].
- val_rm  in  32  Rm value.
- val_rs  in  32  Rs value; only [7:0] used.
- carry_in  in  1  CPSR C.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse; result and carry_out valid.
- result  out  32  operand 2; held until the next accepted start.
- carry_out  out  1  shifter carry; held with result.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- On an accepted start, latch the working word W, carry C, shift type and remaining count R. Then go to DONE if R=0, else go to SHIFT.
- mem_en: W = zero-extended shift_operand; C = carry_in; R = 0.
- imm: W = {24'b0, shift_operand[7:0]}, type ROR, R = 2·shift_operand[11:8].
  - C = carry_in, then updated by the rotation.
- Immediate-amount shift (imm=0, bit4=0): amt = shift_operand[11:7], type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - LSL #0: R=0, C=carry_in.
  - LSR #0 and ASR #0 mean a shift by 32.
  - ROR #0 means RRX: R=1, bit 31 is filled from carry_in.
- Register-amount shift (imm=0, bit4=1): a = val_rs[7:0].
  - a=0: R=0, C=carry_in.
  - LSL/LSR/ASR: R = min(a, 33).
  - ROR: R = ((a−1) mod 32)+1, so a multiple of 32 gives R=32.
- Each SHIFT cycle applies k = min(R, STEP) bits of the latched type to W.
  - C becomes the last bit shifted out: W[32−k] for LSL, W[k−1] otherwise.
  - RRX: W = {C_old, W[31:1]}, C = W[0].
  - R decrements by k; when R ≤ STEP the next state is DONE.
- Iterating LSL/LSR/ASR to 33 yields the ARM results: 0 with C=0 for LSL/LSR; sign fill with C=sign for ASR.
- DONE: done=1, and result/carry_out are driven from W/C.
  - Next state is SHIFT/DONE if start is accepted, else IDLE.
  - result/carry_out are held in IDLE.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, carry_out 0, W/C/R 0.
- Start sampled at the edge ending cycle N: done is high in cycle N+1+⌈R/STEP⌉.
  - R=0 gives done in N+1.
- Back-to-back: a start accepted during DONE begins the next operation with no IDLE bubble.
- A start during SHIFT is dropped; the upstream stage must hold it, since the hazard unit stalls on busy.
- Inputs are sampled only on the accepting edge; later changes have no effect.
- rst during SHIFT aborts: no done pulse, and outputs return to reset values next cycle.
- rst and start together: rst wins.

## Structure
- Shared package `arm_exec_pkg`:
  - shift-type encodings SH_LSL/SH_LSR/SH_ASR/SH_ROR;
  - FSM state enum;
  - constant 33 for the shift clamp.
- Sub-module `shift_step`: combinational k-bit (k ≤ STEP) LSL/LSR/ASR/ROR/RRX of one word, with carry-out.
- Top level holds the FSM, the count computation and the W/C/R registers.

## Test plan
- **Immediate rotate.** STEP=4, imm=1, shift_operand=12'h2FF, start at cycle N.
  - Expect result 0xF000000F and carry_out 1, with done in N+2 only.
- **LSR #0 (shift by 32).** imm=0, shift_operand=12'h020, val_rm=0x80000001.
  - Expect result 0, carry_out 1, done in N+9, busy high in N+1..N+8.
- **RRX.** shift_operand=12'h060, val_rm=3, carry_in=1.
  - Expect result 0x80000001, carry_out 1, done in N+2.
- **Register shifts.**
  - LSL by val_rs=33 on 0xFFFFFFFF: expect result 0, carry_out 0.
  - ROR by val_rs=32 on 0x80000001: expect result 0x80000001, carry_out 1.
  - val_rs=0: expect result = val_rm, carry_out = carry_in, done in N+1.
- **mem_en priority and back-to-back.** mem_en=1, imm=1, shift_operand=12'hABC.
  - Expect result 0x00000ABC, done in N+1.
  - A second start during that DONE yields a second done with no IDLE cycle between them.
- **Ignored start and reset abort.**
  - A start pulse during SHIFT does not change the in-flight result.
  - rst mid-SHIFT: no done; busy, result and carry_out are 0 the next cycle.

Source files
------------

// File: rtl/arm_exec_pkg.sv
// Shared execute-stage definitions: shifter encodings, sequencer states and shift clamps.
package arm_exec_pkg;

    // Barrel-shifter operation encodings, matching instruction bits [6:5]
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Operand-2 sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Register-specified LSL/LSR/ASR amounts saturate here; 33 single-bit steps
    // reproduce the architectural "shift by more than 32" results.
    localparam logic [5:0] SHIFT_CLAMP = 6'd33;

    // Distance that stands for LSR #0 / ASR #0 in the immediate-amount form
    localparam logic [5:0] SHIFT_FULL  = 6'd32;

endpackage

// File: rtl/shift_step.sv
// One partial shifter step: applies k bits (0..32) of LSL/LSR/ASR/ROR, or one RRX, to a word.
import arm_exec_pkg::*;

module shift_step (
    input  logic [31:0]  w_in,
    input  logic         c_in,
    input  shift_type_e  sh_type,
    input  logic         rrx,
    input  logic [5:0]   k,
    output logic [31:0]  w_out,
    output logic         c_out
);

    logic [32:0] lsl_ext;
    logic [32:0] lsr_ext;
    logic [32:0] asr_ext;
    logic [31:0] ror_w;

    // Widened shifts keep the last bit shifted out in the extra bit position,
    // so the carry is read from the same vector as the shifted word.
    always_comb begin
        lsl_ext = {1'b0, w_in} << k;
        lsr_ext = {w_in, 1'b0} >> k;
        asr_ext = $signed({w_in, 1'b0}) >>> k;
        ror_w   = (w_in >> k) | (w_in << (6'd32 - k));
        w_out   = w_in;
        c_out   = c_in;
        if (rrx) begin
            w_out = {c_in, w_in[31:1]};
            c_out = w_in[0];
        end else if (k != 6'd0) begin
            case (sh_type)
                SH_LSL: begin
                    w_out = lsl_ext[31:0];
                    c_out = lsl_ext[32];
                end
                SH_LSR: begin
                    w_out = lsr_ext[32:1];
                    c_out = lsr_ext[0];
                end
                SH_ASR: begin
                    w_out = asr_ext[32:1];
                    c_out = asr_ext[0];
                end
                default: begin
                    w_out = ror_w;
                    c_out = lsr_ext[0];
                end
            endcase
        end
    end

endmodule

// File: rtl/operand2_seq.sv
// Sequenced ARM operand-2 generator: decodes the shift form, then shifts STEP bits per cycle.
import arm_exec_pkg::*;

module operand2_seq #(
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         imm,
    input  logic         mem_en,
    input  logic [11:0]  shift_operand,
    input  logic [31:0]  val_rm,
    input  logic [31:0]  val_rs,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [31:0]  result,
    output logic         carry_out
);

    localparam logic [5:0] STEP_K = 6'(STEP);

    state_e       state_q, state_d;
    logic [31:0]  w_q, w_d;
    logic         c_q, c_d;
    shift_type_e  type_q, type_d;
    logic         rrx_q, rrx_d;
    logic [5:0]   r_q, r_d;
    logic [31:0]  result_q;
    logic         carry_q;

    logic [31:0]  init_w;
    logic         init_c;
    shift_type_e  init_type;
    logic         init_rrx;
    logic [5:0]   init_r;

    logic         accept;
    logic [5:0]   k;
    logic [31:0]  step_w;
    logic         step_c;
    logic [7:0]   rs_amt;
    logic [4:0]   imm_amt;
    logic         unused_rs;

    assign rs_amt    = val_rs[7:0];
    assign imm_amt   = shift_operand[11:7];
    assign unused_rs = ^val_rs[31:8];

    assign accept = start && (state_q != ST_SHIFT);
    assign k      = (r_q < STEP_K) ? r_q : STEP_K;

    // Decode the instruction form into the starting word, carry, type and distance
    always_comb begin
        init_w    = val_rm;
        init_c    = carry_in;
        init_type = shift_type_e'(shift_operand[6:5]);
        init_rrx  = 1'b0;
        init_r    = 6'd0;
        if (mem_en) begin
            init_w    = {20'd0, shift_operand};
            init_type = SH_LSL;
        end else if (imm) begin
            init_w    = {24'd0, shift_operand[7:0]};
            init_type = SH_ROR;
            init_r    = {1'b0, shift_operand[11:8], 1'b0};
        end else if (!shift_operand[4]) begin
            case (init_type)
                SH_LSL: init_r = {1'b0, imm_amt};
                SH_LSR,
                SH_ASR: init_r = (imm_amt == 5'd0) ? SHIFT_FULL : {1'b0, imm_amt};
                default: begin
                    if (imm_amt == 5'd0) begin
                        init_rrx = 1'b1;
                        init_r   = 6'd1;
                    end else begin
                        init_r = {1'b0, imm_amt};
                    end
                end
            endcase
        end else if (rs_amt != 8'd0) begin
            if (init_type == SH_ROR) begin
                init_r = {1'b0, rs_amt[4:0] - 5'd1} + 6'd1;
            end else begin
                init_r = (rs_amt > 8'(SHIFT_CLAMP)) ? SHIFT_CLAMP : rs_amt[5:0];
            end
        end
    end

    shift_step u_shift_step (
        .w_in    (w_q),
        .c_in    (c_q),
        .sh_type (type_q),
        .rrx     (rrx_q),
        .k       (k),
        .w_out   (step_w),
        .c_out   (step_c)
    );

    // Sequencer next state: a new request can be taken in IDLE or DONE, never mid-shift
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (init_r == 6'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_q <= STEP_K) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = (init_r == 6'd0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working-register update: load on acceptance, otherwise advance one step while shifting
    always_comb begin
        w_d    = w_q;
        c_d    = c_q;
        type_d = type_q;
        rrx_d  = rrx_q;
        r_d    = r_q;
        if (accept) begin
            w_d    = init_w;
            c_d    = init_c;
            type_d = init_type;
            rrx_d  = init_rrx;
            r_d    = init_r;
        end else if (state_q == ST_SHIFT) begin
            w_d = step_w;
            c_d = step_c;
            r_d = r_q - k;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers, plus the output copy captured on every entry into DONE so the
    // published result stays stable while a following operation is still shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q      <= 32'd0;
            c_q      <= 1'b0;
            type_q   <= SH_LSL;
            rrx_q    <= 1'b0;
            r_q      <= 6'd0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
        end else begin
            w_q    <= w_d;
            c_q    <= c_d;
            type_q <= type_d;
            rrx_q  <= rrx_d;
            r_q    <= r_d;
            if (state_d == ST_DONE) begin
                result_q <= w_d;
                carry_q  <= c_d;
            end
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_operand2_seq.sv
// Directed self-checking bench for operand2_seq with STEP=4 and hand-computed results.
module tb_operand2_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic         imm;
    logic         mem_en;
    logic [11:0]  shift_operand;
    logic [31:0]  val_rm;
    logic [31:0]  val_rs;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [31:0]  result;
    logic         carry_out;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_seen;

    operand2_seq #(.STEP(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imm           (imm),
        .mem_en        (mem_en),
        .shift_operand (shift_operand),
        .val_rm        (val_rm),
        .val_rs        (val_rs),
        .carry_in      (carry_in),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .carry_out     (carry_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request at a falling edge; the next rising edge accepts it and the task
    // returns at the following falling edge, i.e. in the middle of cycle N+1
    task automatic applyStimulus(input logic m, input logic i, input logic [11:0] so,
                                 input logic [31:0] rm, input logic [31:0] rs, input logic ci);
        mem_en        = m;
        imm           = i;
        shift_operand = so;
        val_rm        = rm;
        val_rs        = rs;
        carry_in      = ci;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        imm           = 1'b0;
        mem_en        = 1'b0;
        shift_operand = 12'h0;
        val_rm        = 32'h0;
        val_rs        = 32'h0;
        carry_in      = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Count falling edges from the current one (=1) until done is seen; -1 when the budget expires
    task automatic waitDone(input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            if (done === 1'b1) begin
                cycles = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        imm = 1'b0;
        mem_en = 1'b0;
        shift_operand = 12'h0;
        val_rm = 32'h0;
        val_rs = 32'h0;
        carry_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_carry", 32'(carry_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] immediate rotate 0xFF ror 4");
        applyStimulus(1'b0, 1'b1, 12'h2FF, 32'h0, 32'h0, 1'b0);
        checkOutput("immrot_busy", 32'(busy), 32'd1);
        waitDone(40, lat);
        checkOutput("immrot_latency", 32'(lat), 32'd2);
        checkOutput("immrot_result", result, 32'hF000000F);
        checkOutput("immrot_carry", 32'(carry_out), 32'd1);
        @(negedge clk);
        checkOutput("immrot_done_pulse", 32'(done), 32'd0);
        checkOutput("immrot_hold", result, 32'hF000000F);

        $display("[TB] LSR #0 as shift by 32");
        applyStimulus(1'b0, 1'b0, 12'h020, 32'h80000001, 32'h0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("lsr32_busy", 32'(busy), 32'd1);
            checkOutput("lsr32_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end
        checkOutput("lsr32_done", 32'(done), 32'd1);
        checkOutput("lsr32_busy_low", 32'(busy), 32'd0);
        checkOutput("lsr32_result", result, 32'h00000000);
        checkOutput("lsr32_carry", 32'(carry_out), 32'd1);
        @(negedge clk);

        $display("[TB] RRX");
        applyStimulus(1'b0, 1'b0, 12'h060, 32'h00000003, 32'h0, 1'b1);
        waitDone(40, lat);
        checkOutput("rrx_latency", 32'(lat), 32'd2);
        checkOutput("rrx_result", result, 32'h80000001);
        checkOutput("rrx_carry", 32'(carry_out), 32'd1);
        @(negedge clk);

        $display("[TB] register LSL by 33");
        applyStimulus(1'b0, 1'b0, 12'h010, 32'hFFFFFFFF, 32'd33, 1'b1);
        waitDone(40, lat);
        checkOutput("reglsl33_latency", 32'(lat), 32'd10);
        checkOutput("reglsl33_result", result, 32'h00000000);
        checkOutput("reglsl33_carry", 32'(carry_out), 32'd0);
        @(negedge clk);

        $display("[TB] register ROR by 32");
        applyStimulus(1'b0, 1'b0, 12'h070, 32'h80000001, 32'd32, 1'b0);
        waitDone(40, lat);
        checkOutput("regror32_latency", 32'(lat), 32'd9);
        checkOutput("regror32_result", result, 32'h80000001);
        checkOutput("regror32_carry", 32'(carry_out), 32'd1);
        @(negedge clk);

        $display("[TB] register shift by zero");
        applyStimulus(1'b0, 1'b0, 12'h010, 32'h12345678, 32'h00000100, 1'b0);
        checkOutput("regzero_done", 32'(done), 32'd1);
        checkOutput("regzero_result", result, 32'h12345678);
        checkOutput("regzero_carry", 32'(carry_out), 32'd0);
        @(negedge clk);

        $display("[TB] start during SHIFT is dropped");
        applyStimulus(1'b0, 1'b0, 12'h020, 32'h80000001, 32'h0, 1'b0);
        imm = 1'b1;
        shift_operand = 12'h0FF;
        carry_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        imm = 1'b0;
        shift_operand = 12'h0;
        @(negedge clk);
        waitDone(40, lat);
        checkOutput("ignored_latency", 32'(lat), 32'd7);
        checkOutput("ignored_result", result, 32'h00000000);
        checkOutput("ignored_carry", 32'(carry_out), 32'd1);
        @(negedge clk);
        checkOutput("ignored_idle", 32'(done | busy), 32'd0);

        $display("[TB] mem_en priority and back-to-back");
        applyStimulus(1'b1, 1'b1, 12'hABC, 32'hDEADBEEF, 32'h0, 1'b1);
        checkOutput("mem_done", 32'(done), 32'd1);
        checkOutput("mem_result", result, 32'h00000ABC);
        checkOutput("mem_carry", 32'(carry_out), 32'd1);
        applyStimulus(1'b1, 1'b0, 12'h123, 32'h0, 32'h0, 1'b1);
        checkOutput("b2b_done", 32'(done), 32'd1);
        checkOutput("b2b_result", result, 32'h00000123);
        checkOutput("b2b_carry", 32'(carry_out), 32'd1);
        @(negedge clk);

        $display("[TB] reset abort mid-shift");
        applyStimulus(1'b0, 1'b0, 12'h020, 32'h80000001, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_carry", 32'(carry_out), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
